skinny_sbox8_dom1_pipelined: RTL and testbench

SKINNY_SBOX8_DOM1_PIPELINED -- requirements
Module: skinny_sbox8_dom1_pipelined

---
 rtl/skinny_sbox8_dom1_pipelined.sv | 171 +++++++++++++++++
 tb/tb_skinny_sbox8_dom1_pipelined.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/skinny_sbox8_dom1_pipelined.sv
// SKINNY-128 8-bit sbox, first-order DOM-indep masked, LANES parallel lanes, input register + 4 gate stages.
// Defining SKINNY_SBOX8_OUT_REFRESH_EN adds a registered output refresh with rout (one extra stage).
module skinny_sbox8_dom1_pipelined #(
    parameter int LANES = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [8*LANES-1:0] si0,
    input  logic [8*LANES-1:0] si1,
    input  logic [8*LANES-1:0] r,
`ifdef SKINNY_SBOX8_OUT_REFRESH_EN
    input  logic [8*LANES-1:0] rout,
`endif
    input  logic               in_valid,
    output logic               in_ready,
    output logic [8*LANES-1:0] bo0,
    output logic [8*LANES-1:0] bo1,
    output logic               out_valid,
    input  logic               out_ready
);

    // Per-lane stage content: input shares, resolved intermediates, this stage's DOM gate registers, randomness.
    typedef struct packed {
        logic [7:0] b0;
        logic [7:0] b1;
        logic [7:0] a0;
        logic [7:0] a1;
        logic [7:0] g0;
        logic [7:0] g1;
        logic [7:0] t0;
        logic [7:0] t1;
        logic [7:0] r;
`ifdef SKINNY_SBOX8_OUT_REFRESH_EN
        logic [7:0] ro;
`endif
    } lane_t;

    localparam int NL = 5;
`ifdef SKINNY_SBOX8_OUT_REFRESH_EN
    localparam int NS = NL + 1;
`else
    localparam int NS = NL;
`endif

    lane_t              stg [NL][LANES];
    lane_t              nxt [NL][LANES];
    logic [NS-1:0]      vld;
    logic               stall;
    logic [8*LANES-1:0] fa0;
    logic [8*LANES-1:0] fa1;
`ifdef SKINNY_SBOX8_OUT_REFRESH_EN
    logic [8*LANES-1:0] fro;
`endif

    // Compress the gates owned by a stage (mask m) into intermediate shares and clear the gate fields.
    function automatic lane_t advance(input lane_t p, input logic [7:0] m);
        lane_t q;
        q    = p;
        q.a0 = (p.a0 & ~m) | ((p.t0 ^ p.g0) & m);
        q.a1 = (p.a1 & ~m) | ((p.t1 ^ p.g1) & m);
        q.g0 = '0;
        q.g1 = '0;
        q.t0 = '0;
        q.t1 = '0;
        return q;
    endfunction

    // Gate j computes NOR(x,y)^z; share 1 carries the complemented operands.
    function automatic lane_t dom_gate(input lane_t l, input logic [2:0] j,
                                       input logic x0, input logic x1,
                                       input logic y0, input logic y1,
                                       input logic z0, input logic z1);
        lane_t q;
        q       = l;
        q.g1[j] = (~x1 & ~y1) ^ z1;
        q.g0[j] = (x0 & y0) ^ z0;
        q.t1[j] = (~x1 & y0) ^ l.r[j];
        q.t0[j] = (~y1 & x0) ^ l.r[j];
        return q;
    endfunction

    function automatic logic [7:0] out_map(input logic [7:0] a);
        return {a[3], a[0], a[1], a[6], a[4], a[2], a[5], a[7]};
    endfunction

    always_comb begin : comb_stages
        lane_t q;
        // NOTE: every always_comb output gets a default before any conditional or partial write, so no latch is inferred.
        q   = '0;
        fa0 = '0;
        fa1 = '0;
`ifdef SKINNY_SBOX8_OUT_REFRESH_EN
        fro = '0;
`endif
        for (int k = 0; k < LANES; k++) begin
            q    = '0;
            q.b0 = si0[8*k +: 8];
            q.b1 = si1[8*k +: 8];
            q.r  = r[8*k +: 8];
`ifdef SKINNY_SBOX8_OUT_REFRESH_EN
            q.ro = rout[8*k +: 8];
`endif
            nxt[0][k] = q;

            q = advance(stg[0][k], 8'h00);
            q = dom_gate(q, 3'd0, q.b0[7], q.b1[7], q.b0[6], q.b1[6], q.b0[4], q.b1[4]);
            q = dom_gate(q, 3'd1, q.b0[3], q.b1[3], q.b0[2], q.b1[2], q.b0[0], q.b1[0]);
            q = dom_gate(q, 3'd2, q.b0[2], q.b1[2], q.b0[1], q.b1[1], q.b0[6], q.b1[6]);
            nxt[1][k] = q;

            q = advance(stg[1][k], 8'h07);
            q = dom_gate(q, 3'd3, q.a0[0], q.a1[0], q.a0[1], q.a1[1], q.b0[5], q.b1[5]);
            q = dom_gate(q, 3'd4, q.a0[1], q.a1[1], q.b0[3], q.b1[3], q.b0[1], q.b1[1]);
            nxt[2][k] = q;

            q = advance(stg[2][k], 8'h18);
            q = dom_gate(q, 3'd5, q.a0[2], q.a1[2], q.a0[3], q.a1[3], q.b0[7], q.b1[7]);
            q = dom_gate(q, 3'd6, q.a0[3], q.a1[3], q.a0[0], q.a1[0], q.b0[3], q.b1[3]);
            nxt[3][k] = q;

            q = advance(stg[3][k], 8'h60);
            q = dom_gate(q, 3'd7, q.a0[4], q.a1[4], q.a0[5], q.a1[5], q.b0[2], q.b1[2]);
            nxt[4][k] = q;

            q = advance(stg[4][k], 8'h80);
            fa0[8*k +: 8] = out_map(q.a0);
            fa1[8*k +: 8] = out_map(q.a1);
`ifdef SKINNY_SBOX8_OUT_REFRESH_EN
            fro[8*k +: 8] = q.ro;
`endif
        end
    end

    assign out_valid = vld[NS-1];
    assign stall     = out_valid & ~out_ready;
    assign in_ready  = ~stall & ~rst;

    // The whole pipe holds on stall so bubbles keep their slots; data registers load freely otherwise.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            vld <= '0;
            for (int s = 0; s < NL; s++) begin
                for (int k = 0; k < LANES; k++) begin
                    stg[s][k] <= '0;
                end
            end
`ifdef SKINNY_SBOX8_OUT_REFRESH_EN
            bo0 <= '0;
            bo1 <= '0;
`endif
        end else if (!stall) begin
            vld <= {vld[NS-2:0], in_valid};
            for (int s = 0; s < NL; s++) begin
                for (int k = 0; k < LANES; k++) begin
                    stg[s][k] <= nxt[s][k];
                end
            end
`ifdef SKINNY_SBOX8_OUT_REFRESH_EN
            bo0 <= fa0 ^ fro;
            bo1 <= fa1 ^ fro;
`endif
        end
    end

`ifndef SKINNY_SBOX8_OUT_REFRESH_EN
    assign bo0 = fa0;
    assign bo1 = fa1;
`endif

endmodule

// File: tb/tb_skinny_sbox8_dom1_pipelined.sv
// Directed bench for skinny_sbox8_dom1_pipelined (LANES=4): reset, latency, streaming, backpressure, mid-stream reset.
// Also covers the SKINNY_SBOX8_OUT_REFRESH_EN build when that macro is defined.
module tb_skinny_sbox8_dom1_pipelined;

    localparam int LANES = 4;
    localparam int W     = 8 * LANES;
`ifdef SKINNY_SBOX8_OUT_REFRESH_EN
    localparam int LAT = 5;
`else
    localparam int LAT = 4;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] si0;
    logic [W-1:0] si1;
    logic [W-1:0] r;
    logic [W-1:0] bo0;
    logic [W-1:0] bo1;
`ifdef SKINNY_SBOX8_OUT_REFRESH_EN
    logic [W-1:0] rout;
`endif

    int           checks   = 0;
    int           failures = 0;
    int           n_out    = 0;
    int           n_stall  = 0;
    logic         last_acc = 1'b0;
    logic         was_stalled = 1'b0;
    logic [W-1:0] snap0;
    logic [W-1:0] snap1;
    logic [W-1:0] exp_q [$];

    skinny_sbox8_dom1_pipelined #(.LANES(LANES)) dut (
        .clk       (clk),
        .rst       (rst),
        .si0       (si0),
        .si1       (si1),
        .r         (r),
`ifdef SKINNY_SBOX8_OUT_REFRESH_EN
        .rout      (rout),
`endif
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .bo0       (bo0),
        .bo1       (bo1),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // Unmasked S8 evaluated straight from the NOR/XOR schedule and output bit mapping.
    function automatic logic [7:0] s8_ref(input logic [7:0] x);
        logic a0, a1, a2, a3, a4, a5, a6, a7;
        a0 = ~(x[7] | x[6]) ^ x[4];
        a1 = ~(x[3] | x[2]) ^ x[0];
        a2 = ~(x[2] | x[1]) ^ x[6];
        a3 = ~(a0 | a1) ^ x[5];
        a4 = ~(a1 | x[3]) ^ x[1];
        a5 = ~(a2 | a3) ^ x[7];
        a6 = ~(a3 | a0) ^ x[3];
        a7 = ~(a4 | a5) ^ x[2];
        return {a3, a0, a1, a6, a4, a2, a5, a7};
    endfunction

    function automatic logic [W-1:0] model_word(input logic [W-1:0] x);
        logic [W-1:0] y;
        y = '0;
        for (int k = 0; k < LANES; k++) y[8*k +: 8] = s8_ref(x[8*k +: 8]);
        return y;
    endfunction

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Fresh random sharing of x and fresh randomness.
    task automatic drive(input logic [W-1:0] x, input logic v);
        logic [W-1:0] s;
        s        = $urandom;
        si0      = s;
        si1      = s ^ x;
        r        = $urandom;
`ifdef SKINNY_SBOX8_OUT_REFRESH_EN
        rout     = $urandom;
`endif
        in_valid = v;
    endtask

    // Scoreboard one clock: check stall behaviour and transfers, record acceptance, then advance.
    task automatic cycle();
        logic acc;
        logic xfer;
        logic [W-1:0] e;
        #1;
        acc  = in_valid && in_ready;
        xfer = out_valid && out_ready;
        if (out_valid && !out_ready) begin
            n_stall++;
            check("stall_in_ready", in_ready, 0);
            if (was_stalled) begin
                check("stall_hold_bo0", bo0, snap0);
                check("stall_hold_bo1", bo1, snap1);
            end
            snap0       = bo0;
            snap1       = bo1;
            was_stalled = 1'b1;
        end else begin
            was_stalled = 1'b0;
        end
        if (xfer) begin
            if (exp_q.size() == 0) begin
                check("spurious_out", out_valid, 0);
            end else begin
                e = exp_q.pop_front();
                check("out_data", bo0 ^ bo1, e);
                n_out++;
            end
        end
        if (acc) exp_q.push_back(model_word(si0 ^ si1));
        last_acc = acc;
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) begin
            drive($urandom, 1'b0);
            cycle();
        end
        check("drain_empty", W'(exp_q.size()), 0);
    endtask

    // One vector with explicit shares; checks exact latency and the unmasked result.
    task automatic single(input string tag, input logic [W-1:0] s0, input logic [W-1:0] s1,
                          input logic [W-1:0] rv, input logic [W-1:0] ro,
                          input logic [W-1:0] expv, output logic [W-1:0] b0_seen);
        si0      = s0;
        si1      = s1;
        r        = rv;
`ifdef SKINNY_SBOX8_OUT_REFRESH_EN
        rout     = ro;
`else
        si0      = s0 | (ro & 0);
`endif
        in_valid = 1'b1;
        cycle();
        for (int k = 1; k < LAT; k++) begin
            drive($urandom, 1'b0);
            cycle();
            check({tag, "_early_valid"}, out_valid, 0);
        end
        drive($urandom, 1'b0);
        cycle();
        check({tag, "_valid"}, out_valid, 1);
        check({tag, "_data"}, bo0 ^ bo1, expv);
        b0_seen = bo0;
    endtask

    initial begin
        logic [W-1:0] w;
        logic [W-1:0] s;
        logic [W-1:0] b0a;
        logic [W-1:0] b0b;
        int           base;
        int           gaps;
        int           idx;
        logic         seen;

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        si0       = '0;
        si1       = '0;
        r         = '0;
`ifdef SKINNY_SBOX8_OUT_REFRESH_EN
        rout      = '0;
`endif
        #1;
        check("rst_in_ready_pre", in_ready, 0);
        repeat (2) begin
            @(posedge clk);
            #1;
            check("rst_out_valid", out_valid, 0);
            check("rst_bo0", bo0, 0);
            check("rst_bo1", bo1, 0);
            check("rst_in_ready", in_ready, 0);
        end
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", in_ready, 1);
        check("post_rst_out_valid", out_valid, 0);

        // Zero input, and all-ones input with random sharing.
        single("zero", '0, '0, $urandom, $urandom, 32'h6565_6565, b0a);
        s = $urandom;
        single("ones", s, s ^ 32'hFFFF_FFFF, $urandom, $urandom, 32'hFFFF_FFFF, b0a);
        drain();

        // 256 back-to-back inputs, lane 0 sweeps every byte value.
        base = n_out;
        gaps = 0;
        seen = 1'b0;
        for (int c = 0; c < 256 + LAT + 8; c++) begin
            if (c < 256) begin
                w      = $urandom;
                w[7:0] = c[7:0];
                drive(w, 1'b1);
            end else begin
                drive($urandom, 1'b0);
            end
            if (out_valid) seen = 1'b1;
            else if (seen && (n_out - base) < 256) gaps++;
            cycle();
            if ((n_out - base) == 256) break;
        end
        check("stream_count", W'(n_out - base), 256);
        check("stream_gaps", W'(gaps), 0);
        drain();

        // Five cycles of backpressure in the middle of a 40-input stream.
        base    = n_out;
        idx     = 0;
        n_stall = 0;
        for (int c = 0; c < 80 && (idx < 40 || exp_q.size() > 0); c++) begin
            out_ready = !(c >= 12 && c < 17);
            if (idx < 40) begin
                w      = $urandom;
                w[7:0] = idx[7:0];
                drive(w, 1'b1);
            end else begin
                drive($urandom, 1'b0);
            end
            cycle();
            if (last_acc) idx++;
        end
        out_ready = 1'b1;
        check("bp_stall_cycles", W'(n_stall), 5);
        check("bp_count", W'(n_out - base), 40);
        check("bp_queue_empty", W'(exp_q.size()), 0);

        // Reset with two inputs in flight: neither may emerge.
        drive(32'h1234_5678, 1'b1);
        cycle();
        drive(32'h9ABC_DEF0, 1'b1);
        cycle();
        in_valid = 1'b0;
        rst      = 1'b1;
        #1;
        check("mid_rst_in_ready", in_ready, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        for (int k = 0; k < 6; k++) begin
            drive($urandom, 1'b0);
            #1;
            check("mid_rst_no_valid", out_valid, 0);
            cycle();
        end
        s = $urandom;
        single("after_rst", s, s ^ 32'hFF00_0201, $urandom, $urandom, 32'hFF65_6A4C, b0a);
        drain();

`ifdef SKINNY_SBOX8_OUT_REFRESH_EN
        // Same shares and randomness, different rout: unmasked value equal, bo0 share different.
        s = $urandom;
        w = $urandom;
        single("refresh_a", s, s, w, 32'h0F1E_2D3C, 32'h6565_6565, b0a);
        drain();
        single("refresh_b", s, s, w, 32'h0F1E_2D3C ^ 32'hA5A5_A5A5, 32'h6565_6565, b0b);
        drain();
        check("rout_changes_bo0", W'(b0a != b0b), 1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
